// File: rtl/blake2_host_tx_pkg.sv
// Shared definitions for the BLAKE2 host transmitter and its receiver.
// Contents:
//   cmd_t        - bus command encodings CONF / START / DATA / LAST
//   state_t      - transmitter FSM states
//   BLOCK_BYTES  - bytes per BLAKE2s block
//   CFG_BYTES    - configuration bytes sent ahead of every job
//   params_legal - start-parameter legality check (kk, nn)
package blake2_host_tx_pkg;

    localparam int BLOCK_BYTES = 64;
    localparam int CFG_BYTES   = 10;

    typedef enum logic [1:0] {
        CMD_CONF  = 2'd0,
        CMD_START = 2'd1,
        CMD_DATA  = 2'd2,
        CMD_LAST  = 2'd3
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_WAIT_RDY,
        ST_BLK,
        ST_HASH
    } state_t;

    // Digest length must be 1..32 and key length 0..32.
    function automatic logic params_legal(input logic [5:0] kk, input logic [5:0] nn);
        return (nn != 6'd0) && (nn <= 6'd32) && (kk <= 6'd32);
    endfunction

endpackage

// File: rtl/blake2_tx_cfg_ser.sv
// Configuration serializer: captures kk, nn and ll on load and presents the
// CONF byte sequence kk, nn, ll[7:0], ll[15:8], ... ll[63:56], one byte per
// cycle while active.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   load          - capture kk/nn/ll and start the sequence
//   kk, nn, ll    - job parameters
//   active        - a CONF byte is presented on data this cycle
//   data          - current CONF byte
//   done          - the byte presented this cycle is the last one
module blake2_tx_cfg_ser
    import blake2_host_tx_pkg::*;
#(
    parameter int LL_W = 64
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [5:0]      kk,
    input  logic [5:0]      nn,
    input  logic [LL_W-1:0] ll,
    output logic            active,
    output logic [7:0]      data,
    output logic            done
);

    logic [8*CFG_BYTES-1:0] shift_reg;
    logic [3:0]             cnt_reg;
    logic [63:0]            ll_ext;

    // The wire format always carries ll as 8 bytes regardless of LL_W.
    assign ll_ext = 64'(ll);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            active    <= 1'b0;
        end else if (load) begin
            // Byte 0 sits in the low bits so a right shift walks the order.
            shift_reg <= {ll_ext, 2'b00, nn, 2'b00, kk};
            cnt_reg   <= '0;
            active    <= 1'b1;
        end else if (active) begin
            shift_reg <= shift_reg >> 8;
            cnt_reg   <= cnt_reg + 4'd1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

    assign data = shift_reg[7:0];
    assign done = active && (cnt_reg == 4'(CFG_BYTES - 1));

endmodule

// File: rtl/blake2_host_tx.sv
// Host-side transmitter for the BLAKE2 byte-wide command/data bus.
// Accepts a job (kk, nn, ll), sends 10 CONF bytes, then 64-byte blocks
// (optional zero-padded key block, then message blocks, last one zero-padded)
// tagged START/DATA/LAST, each block gated on ready_i. Finally mirrors nn
// digest bytes and pulses done_o.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   start_i, kk_i, nn_i, ll_i   - job request and parameters
//   busy_o, err_o               - job in progress / illegal start pulse
//   s_valid_i, s_data_i, s_ready_o - key+message byte source
//   valid_o, cmd_o, data_o      - registered bus toward the core
//   ready_i                     - core ready for the next block
//   hash_v_i, hash_i            - digest bytes from the core
//   digest_v_o, digest_o, done_o - registered digest mirror, completion pulse
module blake2_host_tx
    import blake2_host_tx_pkg::*;
#(
    parameter int BLOCK_BYTES = 64,
    parameter int LL_W        = 64
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [5:0]      kk_i,
    input  logic [5:0]      nn_i,
    input  logic [LL_W-1:0] ll_i,
    output logic            busy_o,
    output logic            err_o,
    input  logic            s_valid_i,
    input  logic [7:0]      s_data_i,
    output logic            s_ready_o,
    output logic            valid_o,
    output logic [1:0]      cmd_o,
    output logic [7:0]      data_o,
    input  logic            ready_i,
    input  logic            hash_v_i,
    input  logic [7:0]      hash_i,
    output logic            digest_v_o,
    output logic [7:0]      digest_o,
    output logic            done_o
);

    localparam logic [5:0] LAST_IDX = 6'(BLOCK_BYTES - 1);

    state_t          state_reg, state_next;
    logic [5:0]      kk_q, nn_q;
    logic [LL_W-1:0] msg_rem;
    logic [5:0]      idx_reg;
    logic [5:0]      dcnt_reg;
    logic            first_reg;     // next/current block is the job's first
    logic            final_reg;     // current block is the job's final
    logic            key_pend_reg;  // key block not yet sent

    logic            legal, accept, src_pos, advance, handshake, blk_end;
    logic            final_now, hash_last;
    logic            cfg_active, cfg_done;
    logic [7:0]      cfg_data;
    logic            emit_v;
    cmd_t            emit_cmd;
    logic [7:0]      emit_data;

    assign legal  = params_legal(kk_i, nn_i);
    assign accept = (state_reg == ST_IDLE) && start_i && legal;

    // Key block ends the job only when there is no message; otherwise a
    // message block is final when what remains fits in one block.
    assign final_now = key_pend_reg ? (msg_rem == '0)
                                    : (msg_rem <= LL_W'(BLOCK_BYTES));

    assign src_pos   = key_pend_reg ? (idx_reg < kk_q) : (msg_rem != '0);
    assign advance   = (state_reg == ST_BLK) && (!src_pos || s_valid_i);
    assign handshake = (state_reg == ST_BLK) && src_pos && s_valid_i;
    assign blk_end   = advance && (idx_reg == LAST_IDX);
    assign hash_last = hash_v_i && ((dcnt_reg + 6'd1) == nn_q);

    assign busy_o = (state_reg != ST_IDLE);

    blake2_tx_cfg_ser #(
        .LL_W (LL_W)
    ) u_cfg_ser (
        .clk    (clk),
        .rst    (reset),
        .load   (accept),
        .kk     (kk_i),
        .nn     (nn_i),
        .ll     (ll_i),
        .active (cfg_active),
        .data   (cfg_data),
        .done   (cfg_done)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:     if (accept)    state_next = ST_CFG;
            ST_CFG:      if (cfg_done)  state_next = ST_WAIT_RDY;
            ST_WAIT_RDY: if (ready_i)   state_next = ST_BLK;
            ST_BLK:      if (blk_end)   state_next = final_reg ? ST_HASH : ST_WAIT_RDY;
            ST_HASH:     if (hash_last) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // Output decode: what goes onto the bus at the next edge.
    always_comb begin
        s_ready_o = 1'b0;
        emit_v    = 1'b0;
        emit_cmd  = CMD_DATA;
        emit_data = 8'h00;
        unique case (state_reg)
            ST_CFG: begin
                emit_v    = cfg_active;
                emit_cmd  = CMD_CONF;
                emit_data = cfg_data;
            end
            ST_BLK: begin
                s_ready_o = src_pos;
                emit_v    = advance;
                if (idx_reg == 6'd0 && first_reg) begin
                    emit_cmd = CMD_START;
                end else if (idx_reg == LAST_IDX && final_reg) begin
                    emit_cmd = CMD_LAST;
                end else begin
                    emit_cmd = CMD_DATA;
                end
                emit_data = src_pos ? s_data_i : 8'h00;
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kk_q         <= '0;
            nn_q         <= '0;
            msg_rem      <= '0;
            idx_reg      <= '0;
            dcnt_reg     <= '0;
            first_reg    <= 1'b0;
            final_reg    <= 1'b0;
            key_pend_reg <= 1'b0;
            valid_o      <= 1'b0;
            cmd_o        <= '0;
            data_o       <= '0;
            digest_v_o   <= 1'b0;
            digest_o     <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            err_o   <= (state_reg == ST_IDLE) && start_i && !legal;
            valid_o <= emit_v;
            cmd_o   <= emit_v ? emit_cmd : CMD_CONF;
            data_o  <= emit_v ? emit_data : 8'h00;

            if (accept) begin
                kk_q         <= kk_i;
                nn_q         <= nn_i;
                msg_rem      <= ll_i;
                key_pend_reg <= (kk_i != 6'd0);
                first_reg    <= 1'b1;
            end

            if (state_reg == ST_WAIT_RDY && ready_i) begin
                idx_reg   <= '0;
                final_reg <= final_now;
            end

            if (advance) begin
                idx_reg <= idx_reg + 6'd1;
            end
            if (handshake && !key_pend_reg) begin
                msg_rem <= msg_rem - LL_W'(1);
            end
            if (blk_end) begin
                first_reg    <= 1'b0;
                key_pend_reg <= 1'b0;
                dcnt_reg     <= '0;
            end

            if (state_reg == ST_HASH) begin
                digest_v_o <= hash_v_i;
                done_o     <= hash_last;
                if (hash_v_i) begin
                    digest_o <= hash_i;
                    dcnt_reg <= dcnt_reg + 6'd1;
                end
            end else begin
                digest_v_o <= 1'b0;
                done_o     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blake2_host_tx.sv
`timescale 1ns/1ps
module tb_blake2_host_tx;

    localparam int LL_W = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_i;
    logic [5:0]      kk_i, nn_i;
    logic [LL_W-1:0] ll_i;
    logic            busy_o, err_o;
    logic            s_valid_i;
    logic [7:0]      s_data_i;
    logic            s_ready_o;
    logic            valid_o;
    logic [1:0]      cmd_o;
    logic [7:0]      data_o;
    logic            ready_i;
    logic            hash_v_i;
    logic [7:0]      hash_i;
    logic            digest_v_o;
    logic [7:0]      digest_o;
    logic            done_o;

    always #5 clk = ~clk;

    blake2_host_tx #(.BLOCK_BYTES(64), .LL_W(LL_W)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i),
        .ll_i(ll_i), .busy_o(busy_o), .err_o(err_o), .s_valid_i(s_valid_i),
        .s_data_i(s_data_i), .s_ready_o(s_ready_o), .valid_o(valid_o),
        .cmd_o(cmd_o), .data_o(data_o), .ready_i(ready_i), .hash_v_i(hash_v_i),
        .hash_i(hash_i), .digest_v_o(digest_v_o), .digest_o(digest_o), .done_o(done_o)
    );

    // Scoreboard: {cmd, data} expected on the bus, digest bytes expected back.
    logic [9:0] exp_bus[$];
    logic [9:0] obs_bus[$];
    int         obs_cyc[$];
    logic [7:0] exp_dig[$];
    logic [7:0] obs_dig[$];
    logic [7:0] src_q[$];
    int src_ptr, stall_ptr, stall_left;
    int cyc, done_cnt, done_bad, err_cnt, sready_seen;
    int checks, errors;

    // One clock: account the handshake of the coming edge, sample outputs at
    // the falling edge, then present the next source byte.
    task automatic tick();
        bit hs;
        hs = s_valid_i && s_ready_o;
        @(negedge clk);
        cyc++;
        if (hs) src_ptr++;
        if (s_ready_o) sready_seen++;
        if (valid_o) begin
            obs_bus.push_back({cmd_o, data_o});
            obs_cyc.push_back(cyc);
        end
        if (digest_v_o) obs_dig.push_back(digest_o);
        if (done_o) begin
            done_cnt++;
            if (!digest_v_o) done_bad++;
        end
        if (err_o) err_cnt++;
        if (src_ptr < src_q.size()) begin
            if (src_ptr == stall_ptr && stall_left > 0 && s_ready_o) begin
                s_valid_i = 1'b0;
                stall_left--;
            end else begin
                s_valid_i = 1'b1;
                s_data_i  = src_q[src_ptr];
            end
        end else begin
            s_valid_i = 1'b0;
            s_data_i  = 8'h00;
        end
    endtask

    task automatic load_src(input int n);
        src_q.delete();
        src_ptr = 0;
        for (int i = 0; i < n; i++) src_q.push_back(8'($urandom_range(1, 255)));
    endtask

    // Reference model of the bus stream for one job.
    task automatic push_expected(input int kk, input int nn, input int ll);
        logic [63:0] llv;
        int nblk, mb, pos;
        logic [7:0] b;
        logic [1:0] c;
        llv = 64'(ll);
        exp_bus.delete();
        exp_bus.push_back({2'd0, 8'(kk)});
        exp_bus.push_back({2'd0, 8'(nn)});
        for (int k = 0; k < 8; k++) exp_bus.push_back({2'd0, llv[8*k +: 8]});
        nblk = ((kk > 0) ? 1 : 0) + (ll + 63) / 64;
        if (nblk == 0) nblk = 1;
        for (int blk = 0; blk < nblk; blk++) begin
            for (int i = 0; i < 64; i++) begin
                if (kk > 0 && blk == 0) begin
                    b = (i < kk) ? src_q[i] : 8'h00;
                end else begin
                    mb  = (kk > 0) ? blk - 1 : blk;
                    pos = mb * 64 + i;
                    b   = (pos < ll) ? src_q[kk + pos] : 8'h00;
                end
                if (blk == 0 && i == 0)             c = 2'd1;
                else if (blk == nblk - 1 && i == 63) c = 2'd3;
                else                                 c = 2'd2;
                exp_bus.push_back({c, b});
            end
        end
    endtask

    task automatic start_job(input int kk, input int nn, input int ll);
        obs_bus.delete(); obs_cyc.delete(); obs_dig.delete(); exp_dig.delete();
        done_cnt = 0; done_bad = 0; err_cnt = 0;
        push_expected(kk, nn, ll);
        kk_i = 6'(kk); nn_i = 6'(nn); ll_i = LL_W'(ll);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (obs_bus.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (obs_bus.size() >= n);
    endtask

    task automatic run_hash(input int nn);
        for (int i = 0; i < nn; i++) begin
            hash_v_i = 1'b1;
            hash_i   = 8'($urandom);
            exp_dig.push_back(hash_i);
            tick();
        end
        hash_v_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({valid_o, cmd_o, data_o, busy_o, err_o, s_ready_o, digest_v_o, digest_o, done_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b cmd=%0d d=%02h busy=%b err=%b srdy=%b dv=%b dg=%02h done=%b, want all 0",
                     valid_o, cmd_o, data_o, busy_o, err_o, s_ready_o, digest_v_o, digest_o, done_o);
        end
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b, want 0 0", busy_o, valid_o);
        end
    endtask

    task automatic test_single_block();
        bit ok;
        logic [9:0] e, o;
        src_q.delete(); src_ptr = 0;
        src_q.push_back(8'h61); src_q.push_back(8'h62); src_q.push_back(8'h63);
        start_job(0, 32, 3);
        run_until(74, 400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: got %0d bytes, want 74", obs_bus.size()); end
        for (int k = 0; k < 74; k++) begin
            e = exp_bus.pop_front();
            o = (obs_bus.size() > 0) ? obs_bus.pop_front() : 10'h3ff;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_bus[%0d]: got cmd=%0d data=%02h, want cmd=%0d data=%02h", k, o[9:8], o[7:0], e[9:8], e[7:0]);
            end
        end
        run_hash(32);
        for (int k = 0; k < 32; k++) begin
            e[7:0] = exp_dig.pop_front();
            o[7:0] = (obs_dig.size() > 0) ? obs_dig.pop_front() : 8'hxx;
            checks++;
            if (o[7:0] !== e[7:0]) begin
                errors++;
                $display("FAIL single_digest[%0d]: got %02h, want %02h", k, o[7:0], e[7:0]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_bad != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got pulses=%0d misaligned=%0d busy=%b, want 1 0 0", done_cnt, done_bad, busy_o);
        end
    endtask

    task automatic test_empty_message();
        bit ok;
        logic [9:0] e, o;
        load_src(0);
        sready_seen = 0;
        start_job(0, 16, 0);
        run_until(74, 400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL empty_timeout: got %0d bytes, want 74", obs_bus.size()); end
        for (int k = 0; k < 74; k++) begin
            e = exp_bus.pop_front();
            o = (obs_bus.size() > 0) ? obs_bus.pop_front() : 10'h3ff;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL empty_bus[%0d]: got cmd=%0d data=%02h, want cmd=%0d data=%02h", k, o[9:8], o[7:0], e[9:8], e[7:0]);
            end
        end
        checks++;
        if (sready_seen != 0) begin
            errors++;
            $display("FAIL empty_sready: got %0d ready cycles, want 0", sready_seen);
        end
        run_hash(16);
        checks++;
        if (done_cnt != 1 || obs_dig.size() != 16) begin
            errors++;
            $display("FAIL empty_done: got pulses=%0d digest=%0d, want 1 16", done_cnt, obs_dig.size());
        end
    endtask

    task automatic test_multi_block();
        bit ok;
        int n0;
        logic [9:0] e, o;
        load_src(67);
        start_job(2, 8, 65);
        run_until(74, 400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL multi_key_timeout: got %0d bytes, want 74", obs_bus.size()); end
        ready_i = 1'b0;
        n0 = obs_bus.size();
        repeat (5) tick();
        checks++;
        if (obs_bus.size() != n0) begin
            errors++;
            $display("FAIL multi_ready_hold: got %0d bytes while ready low, want 0", obs_bus.size() - n0);
        end
        ready_i = 1'b1;
        run_until(202, 600, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL multi_timeout: got %0d bytes, want 202", obs_bus.size()); end
        for (int k = 0; k < 202; k++) begin
            e = exp_bus.pop_front();
            o = (obs_bus.size() > 0) ? obs_bus.pop_front() : 10'h3ff;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL multi_bus[%0d]: got cmd=%0d data=%02h, want cmd=%0d data=%02h", k, o[9:8], o[7:0], e[9:8], e[7:0]);
            end
        end
        run_hash(8);
        for (int k = 0; k < 8; k++) begin
            e[7:0] = exp_dig.pop_front();
            o[7:0] = (obs_dig.size() > 0) ? obs_dig.pop_front() : 8'hxx;
            checks++;
            if (o[7:0] !== e[7:0]) begin
                errors++;
                $display("FAIL multi_digest[%0d]: got %02h, want %02h", k, o[7:0], e[7:0]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_bad != 0) begin
            errors++;
            $display("FAIL multi_done: got pulses=%0d misaligned=%0d, want 1 0", done_cnt, done_bad);
        end
    endtask

    task automatic test_source_stall();
        bit ok;
        logic [9:0] e, o;
        load_src(20);
        stall_ptr = 10; stall_left = 3;
        start_job(0, 4, 20);
        run_until(74, 400, ok);
        stall_ptr = -1;
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_timeout: got %0d bytes, want 74", obs_bus.size()); end
        if (obs_cyc.size() >= 21) begin
            checks++;
            if (obs_cyc[20] - obs_cyc[19] != 4 || obs_cyc[19] - obs_cyc[18] != 1) begin
                errors++;
                $display("FAIL stall_gap: got spacing %0d then %0d cycles, want 1 then 4",
                         obs_cyc[19] - obs_cyc[18], obs_cyc[20] - obs_cyc[19]);
            end
        end
        for (int k = 0; k < 74; k++) begin
            e = exp_bus.pop_front();
            o = (obs_bus.size() > 0) ? obs_bus.pop_front() : 10'h3ff;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall_bus[%0d]: got cmd=%0d data=%02h, want cmd=%0d data=%02h", k, o[9:8], o[7:0], e[9:8], e[7:0]);
            end
        end
        run_hash(4);
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL stall_done: got %0d pulses, want 1", done_cnt); end
    endtask

    task automatic test_errors();
        logic [5:0] kk_tab [3];
        logic [5:0] nn_tab [3];
        kk_tab[0] = 6'd0;  nn_tab[0] = 6'd0;
        kk_tab[1] = 6'd4;  nn_tab[1] = 6'd40;
        kk_tab[2] = 6'd33; nn_tab[2] = 6'd16;
        for (int t = 0; t < 3; t++) begin
            err_cnt = 0;
            obs_bus.delete();
            kk_i = kk_tab[t]; nn_i = nn_tab[t]; ll_i = LL_W'(5);
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            checks++;
            if (err_o !== 1'b1 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL err_start[%0d]: got err=%b busy=%b, want 1 0", t, err_o, busy_o);
            end
            repeat (4) tick();
            checks++;
            if (err_cnt != 1 || busy_o !== 1'b0 || obs_bus.size() != 0) begin
                errors++;
                $display("FAIL err_after[%0d]: got pulses=%0d busy=%b bytes=%0d, want 1 0 0", t, err_cnt, busy_o, obs_bus.size());
            end
        end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        logic [9:0] e, o;
        load_src(6);
        start_job(1, 2, 5);
        repeat (3) tick();
        kk_i = 6'd0; nn_i = 6'd0; ll_i = '0;
        start_i = 1'b1; tick(); start_i = 1'b0;
        repeat (12) tick();
        kk_i = 6'd3; nn_i = 6'd5; ll_i = LL_W'(1);
        start_i = 1'b1; tick(); start_i = 1'b0;
        run_until(138, 500, ok);
        repeat (3) tick();
        checks++;
        if (!ok || err_cnt != 0 || obs_bus.size() != 138) begin
            errors++;
            $display("FAIL busy_start: got ok=%0d err_pulses=%0d bytes=%0d, want 1 0 138", ok, err_cnt, obs_bus.size());
        end
        for (int k = 0; k < 138; k++) begin
            e = exp_bus.pop_front();
            o = (obs_bus.size() > 0) ? obs_bus.pop_front() : 10'h3ff;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL busy_bus[%0d]: got cmd=%0d data=%02h, want cmd=%0d data=%02h", k, o[9:8], o[7:0], e[9:8], e[7:0]);
            end
        end
        run_hash(2);
        checks++;
        if (done_cnt != 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_done: got pulses=%0d busy=%b, want 1 0", done_cnt, busy_o);
        end
        obs_dig.delete();
        hash_v_i = 1'b1; hash_i = 8'h5a;
        repeat (3) tick();
        hash_v_i = 1'b0;
        tick();
        checks++;
        if (obs_dig.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL idle_hash: got %0d digest bytes and %0d done pulses, want 0 1", obs_dig.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        logic [9:0] e, o;
        load_src(100);
        start_job(0, 4, 100);
        run_until(30, 400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midrst_timeout: got %0d bytes, want 30", obs_bus.size()); end
        reset = 1'b1;
        #1;
        checks++;
        if ({valid_o, cmd_o, data_o, busy_o, s_ready_o, digest_v_o, done_o} !== '0) begin
            errors++;
            $display("FAIL midrst_async: got v=%b cmd=%0d d=%02h busy=%b srdy=%b, want all 0", valid_o, cmd_o, data_o, busy_o, s_ready_o);
        end
        @(posedge clk); #1;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_edge: got valid=%b busy=%b, want 0 0", valid_o, busy_o);
        end
        @(negedge clk);
        reset = 1'b0;
        s_valid_i = 1'b0;
        tick();
        load_src(13);
        start_job(3, 5, 10);
        run_until(138, 500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL after_rst_timeout: got %0d bytes, want 138", obs_bus.size()); end
        for (int k = 0; k < 138; k++) begin
            e = exp_bus.pop_front();
            o = (obs_bus.size() > 0) ? obs_bus.pop_front() : 10'h3ff;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL after_rst_bus[%0d]: got cmd=%0d data=%02h, want cmd=%0d data=%02h", k, o[9:8], o[7:0], e[9:8], e[7:0]);
            end
        end
        run_hash(5);
        for (int k = 0; k < 5; k++) begin
            e[7:0] = exp_dig.pop_front();
            o[7:0] = (obs_dig.size() > 0) ? obs_dig.pop_front() : 8'hxx;
            checks++;
            if (o[7:0] !== e[7:0]) begin
                errors++;
                $display("FAIL after_rst_digest[%0d]: got %02h, want %02h", k, o[7:0], e[7:0]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_bad != 0) begin
            errors++;
            $display("FAIL after_rst_done: got pulses=%0d misaligned=%0d, want 1 0", done_cnt, done_bad);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        src_ptr = 0; stall_ptr = -1; stall_left = 0;
        done_cnt = 0; done_bad = 0; err_cnt = 0; sready_seen = 0;
        reset = 1'b1; start_i = 1'b0; kk_i = '0; nn_i = '0; ll_i = '0;
        s_valid_i = 1'b0; s_data_i = '0; ready_i = 1'b1;
        hash_v_i = 1'b0; hash_i = '0;

        test_reset();
        test_single_block();
        test_empty_message();
        test_multi_block();
        test_source_stall();
        test_errors();
        test_busy_ignore();
        test_reset_mid_job();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blake2_host_tx.md
Name: blake2_host_tx

Overview:
Host-side transmitter for the BLAKE2 byte-wide command/data bus; it drives the valid/cmd/data inputs of the core's I/O interface. It accepts a hash job (kk, nn, ll) and a key+message byte stream. It then emits the 10 configuration bytes, 64-byte blocks (key block zero-padded, final block zero-padded) with START/DATA/LAST tagging, and gates each block on the core's ready. It then collects nn digest bytes and signals completion.

Parameters:
BLOCK_BYTES, 64, bytes per BLAKE2s block; fixes block counter width at 6 bits.
LL_W, 64, width of the message length field and its down-counter.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start_i  in  1  job request pulse; sampled in IDLE only
kk_i  in  6  key length in bytes, 0..32
nn_i  in  6  digest length in bytes, 1..32
ll_i  in  LL_W  message length in bytes, key excluded
busy_o  out  1  high from accepted start until done_o
err_o  out  1  one-cycle pulse: start rejected (nn_i==0, nn_i>32 or kk_i>32)
s_valid_i  in  1  source byte valid
s_data_i  in  8  source byte; key bytes first, then message
s_ready_o  out  1  source byte accepted when s_valid_i & s_ready_o
valid_o  out  1  bus byte valid (registered)
cmd_o  out  2  0 CONF, 1 START, 2 DATA, 3 LAST (registered)
data_o  out  8  bus byte (registered)
ready_i  in  1  core ready-for-block, from the I/O interface ready output
hash_v_i  in  1  digest byte valid from core
hash_i  in  8  digest byte
digest_v_o  out  1  registered copy of hash_v_i while in HASH
digest_o  out  8  registered copy of hash_i
done_o  out  1  one-cycle pulse after nn-th digest byte

Behaviour:
- Reset: state IDLE. All outputs and counters are 0.
- FSM states: IDLE, CFG, WAIT_RDY, BLK, HASH.
- IDLE -> CFG on start_i when parameters are legal. kk, nn and ll are latched into kk_q, nn_q and msg_rem. On an illegal start, pulse err_o and stay in IDLE.
- CFG: 10 consecutive cycles with valid_o=1 and cmd=CONF. Data order is kk, nn, then ll as 8 bytes LSB first, so the receiver's shift register ends with byte 0 in ll[7:0]. Then go to WAIT_RDY.
- WAIT_RDY: valid_o=0. When ready_i==1, go to BLK with byte index idx=0. At entry, decide whether this block is the final block:
  - Key block pending (kk_q!=0, not yet sent): final when msg_rem==0.
  - Otherwise: final when msg_rem<=64.
  - kk==0 and ll==0: a single all-zero block is sent, both first and final.
- BLK: one byte per emitted position, idx 0..63.
  - Source positions: key block idx<kk_q, or message block while msg_rem>0. On these, s_ready_o=1; the byte is emitted the cycle after the handshake (latency 1); if s_valid_i is low, valid_o=0 and idx holds (gaps allowed).
  - Pad positions: s_ready_o=0; data 0x00 emitted on consecutive cycles.
  - msg_rem decrements by 1 per accepted message byte, never below 0. Key bytes do not decrement it.
- cmd tagging within BLK:
  - idx 0 of the first block: START.
  - idx 63 of the final block: LAST.
  - All other bytes: DATA. A single-block job therefore carries START at idx 0 and LAST at idx 63.
- After idx 63: a non-final block goes to WAIT_RDY. The final block goes to HASH with the digest counter at 0.
- ready_i is checked only in WAIT_RDY. Once a block starts it always completes, whatever ready_i does.
- HASH: each hash_v_i cycle increments the digest counter and is mirrored to digest_v_o/digest_o one cycle later. When the count reaches nn_q, pulse done_o on the same cycle as the last digest_v_o, then go to IDLE. hash_v_i outside HASH is ignored.
- start_i while busy_o=1 is ignored, with no error.
- Reset mid-job returns to IDLE immediately with outputs 0. The downstream receiver recovers on the next CONF.
- No CONF byte is ever emitted outside CFG, so the receiver's block counter stays aligned.

Decomposition:
- Shared package holds the CMD_CONF/START/DATA/LAST encodings, BLOCK_BYTES, CFG_BYTES=10, and the FSM state enum, shared with the receiver side.
- One sub-module, blake2_tx_cfg_ser: loads kk, nn and ll, and emits the 10 CONF bytes with a 4-bit counter and a done flag.

Test Plan:
- kk=0, nn=32, ll=3, bytes 61 62 63: 10 CONF bytes (00 20 03 00×7), then START 61, DATA 62 63, 60 DATA 00 pad bytes, LAST 00 at idx 63. 32 hash_v_i -> done_o pulse.
- kk=0, ll=0: one all-zero block, START at idx 0, LAST at idx 63, s_ready_o never high.
- kk=2, ll=65: three blocks. Key block = 2 key bytes + 62 pad with START at idx 0. Message block 2 is full DATA. Block 3 has 1 byte, then pad, then LAST at idx 63. The bench holds ready_i=0 for 5 cycles before block 2; no valid_o is issued meanwhile.
- Source stalls: s_valid_i low 3 cycles at idx 10 -> valid_o gap of 3 cycles, idx holds, no byte lost or duplicated.
- start_i with nn=0 -> err_o pulse, busy_o stays 0. start_i while busy -> ignored.
- reset asserted at BLK idx 20 -> all outputs 0 next edge; a new job then runs normally from CFG.
